draw_back_anim: RTL and testbench
=================================

Name: draw_back_anim

Overview:
Parametrised, animated successor to the static background/border renderer. It produces the 4-bit background colour code per pixel: playfield border, plus a tiled text message (title, game-over, and new win screen). The message scrolls up into place, holds, then blinks. It sits in the VGA pixel path beside the ball/paddle/brick renderers and feeds the colour priority mux with a fixed 1-cycle latency.

Parameters:
LEFT, 16, x of playfield left edge (pixels)
TOP, 16, y of playfield top edge (pixels)
MAXX, 512, playfield width (pixels)
MAXY, 448, playfield height (pixels)
BORDER, 72, border thickness outside playfield (pixels)
TILE_LOG2, 4, log2 of glyph tile size (16 px)
MSG_ROWS, 18, message area height in tiles, starting at TOP
BAND1_ROW, 6, first tile row of colour band 2
BAND2_ROW, 12, first tile row of colour band 3
SCROLL_STEP, 8, pixels the message rises per frame
HOLD_FRAMES, 60, frames shown steady before blinking
BLINK_FRAMES, 30, frames per blink half-period

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
vcounter  in  11  current pixel row
hcounter  in  12  current pixel column
frame_start  in  1  one-cycle pulse, once per frame, during vblank
dead  in  1  game-over mode request
init  in  1  title mode request
win  in  1  win mode request
out  out  4  background colour code, registered
anim_done  out  1  high once scroll-in is complete (HOLD/BLINK), registered

Behaviour:
- Reset (async, rst_n=0): state=PLAY, mode=PLAY, offset=0, frame_cnt=0, blink_on=1, out=4'b0000, anim_done=0.
- Mode request priority is dead > win > init > none (PLAY). It is sampled only on frame_start, so a mid-frame change takes effect at the next frame_start.
- States: PLAY, SCROLL, HOLD, BLINK. Transitions are evaluated only on frame_start cycles.
  - Sampled mode differs from latched mode: latch the new mode.
    - New mode PLAY: go to PLAY, offset=0.
    - Otherwise: go to SCROLL, offset=MSG_ROWS<<TILE_LOG2, frame_cnt=0, blink_on=1.
    - A mode change overrides every other transition in the same cycle.
  - SCROLL: offset -= SCROLL_STEP, saturating at 0. When the new offset is 0, go to HOLD with frame_cnt=0.
  - HOLD: frame_cnt++. On reaching HOLD_FRAMES-1, go to BLINK with frame_cnt=0.
  - BLINK: frame_cnt++. On reaching BLINK_FRAMES-1, toggle blink_on and set frame_cnt=0.
  - PLAY: idle.
- anim_done = (state==HOLD or BLINK), registered with the state.
- Pixel path (combinational from counters, then registered, so out is valid 1 clk after the counters):
  - Playfield-message region: TOP <= v < TOP+(MSG_ROWS<<TILE_LOG2) and LEFT <= h < LEFT+MAXX.
  - Shifted row: sv = v - TOP - offset, valid only when v >= TOP+offset. Tile row = sv>>TILE_LOG2; tile col = (h-LEFT)>>TILE_LOG2 (5 bits each).
  - Glyph bit comes from the existing glyph ROM: select 00=init, 01=dead, 11=win.
  - Pixel is lit when glyph bit=1, mode≠PLAY, sv is valid, and (state≠BLINK or blink_on).
  - dead bands: rows < BAND1_ROW → 1011; rows < BAND2_ROW → 1100; otherwise 1010.
  - init: rows 6..8 in columns 5..MAXX/16-6 → 1100 (subtitle). Otherwise rows < BAND2_ROW → 1110, else 1100.
  - win: 1101, all rows.
  - Unlit pixels inside the playfield → 0000.
  - Border: pixel outside the playfield but within BORDER of any edge → 1111. Everything else → 0000.
- Arithmetic:
  - Comparisons use width-extended unsigned values, so v+BORDER and h+BORDER must not wrap.
  - Subtraction results below TOP/LEFT are treated as outside the region, never as wrapped indices.
- frame_start asserted during reset is ignored.

Decomposition:
- Shared package/include holds the geometry constants (LEFT, TOP, MAXX, MAXY), the colour codes (BORDER_C=1111, DEAD_A/B/C, INIT_A/B, WIN_C), and the glyph select encodings.
- One natural sub-module: draw_back_anim_ctrl, containing the mode latch, state machine, offset, frame counter and blink toggle.
- The pixel path and glyph ROM instance stay in the top module.

Test Plan:
- Reset, then a pixel at v=TOP, h=LEFT-1 → out=1111 one clk later. Pixel at v=0, h=0 → 0000. anim_done=0.
- Assert dead, then one frame_start → state SCROLL, offset=288. After 36 further frame_starts → offset=0, anim_done=1. A lit glyph pixel in row 2 → 1011.
- In SCROLL with offset=144: pixel at v=TOP+100 → 0000 even where the glyph bit is 1. Pixel at v=TOP+144 shows tile row 0.
- After HOLD, the 60th frame_start enters BLINK. After 30 more frame_starts, lit pixels → 0000. After 30 more → colour restored.
- With dead and win both asserted at frame_start → select 01 and dead colours. Drop dead mid-scroll → restart SCROLL in win mode at offset=288, lit pixels → 1101.
- Deassert all requests → PLAY on the next frame_start: playfield out=0000, border still 1111. Assert rst_n=0 mid-BLINK → out=0000 and state PLAY immediately, without waiting for a clock.

Source files
------------

// File: rtl/draw_back_anim_pkg.sv
// Shared constants for the animated background renderer: default geometry,
// colour codes, glyph select encodings, and the glyph ROM contents.
package draw_back_anim_pkg;

    localparam int LEFT         = 16;
    localparam int TOP          = 16;
    localparam int MAXX         = 512;
    localparam int MAXY         = 448;
    localparam int BORDER       = 72;
    localparam int TILE_LOG2    = 4;
    localparam int MSG_ROWS     = 18;
    localparam int BAND1_ROW    = 6;
    localparam int BAND2_ROW    = 12;
    localparam int SCROLL_STEP  = 8;
    localparam int HOLD_FRAMES  = 60;
    localparam int BLINK_FRAMES = 30;

    localparam int SUB_ROW_LO = 6;
    localparam int SUB_ROW_HI = 8;
    localparam int SUB_COL_LO = 5;

    localparam logic [3:0] BLANK_C  = 4'b0000;
    localparam logic [3:0] BORDER_C = 4'b1111;
    localparam logic [3:0] DEAD_A   = 4'b1011;
    localparam logic [3:0] DEAD_B   = 4'b1100;
    localparam logic [3:0] DEAD_C   = 4'b1010;
    localparam logic [3:0] INIT_A   = 4'b1110;
    localparam logic [3:0] INIT_B   = 4'b1100;
    localparam logic [3:0] WIN_C    = 4'b1101;

    localparam logic [1:0] SEL_INIT = 2'b00;
    localparam logic [1:0] SEL_DEAD = 2'b01;
    localparam logic [1:0] SEL_WIN  = 2'b11;

    typedef enum logic [1:0] {
        MODE_PLAY = 2'd0,
        MODE_INIT = 2'd1,
        MODE_DEAD = 2'd2,
        MODE_WIN  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HOLD   = 2'd2,
        ST_BLINK  = 2'd3
    } state_e;

    // Glyph ROM: one bit per (message select, tile row, tile column).
    function automatic logic glyph_bit(input logic [1:0] sel,
                                       input logic [4:0] row,
                                       input logic [4:0] col);
        return (row[0] ^ col[0] ^ sel[0]) | (row[2] & col[1] & ~sel[1]);
    endfunction

endpackage

// File: rtl/draw_back_anim_ctrl.sv
// Message animation controller: mode latch, scroll/hold/blink sequencing,
// scroll offset, frame counter and blink phase. Advances only on frame_start.
module draw_back_anim_ctrl #(
    parameter int MSG_ROWS     = draw_back_anim_pkg::MSG_ROWS,
    parameter int TILE_LOG2    = draw_back_anim_pkg::TILE_LOG2,
    parameter int SCROLL_STEP  = draw_back_anim_pkg::SCROLL_STEP,
    parameter int HOLD_FRAMES  = draw_back_anim_pkg::HOLD_FRAMES,
    parameter int BLINK_FRAMES = draw_back_anim_pkg::BLINK_FRAMES,
    parameter int OFS_W        = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_i,
    input  logic             dead_i,
    input  logic             init_i,
    input  logic             win_i,
    output logic [1:0]       mode_o,
    output logic [1:0]       state_o,
    output logic [OFS_W-1:0] offset_o,
    output logic             blink_on_o,
    output logic             anim_done_o
);
    import draw_back_anim_pkg::*;

    localparam int MSG_PIX  = MSG_ROWS << TILE_LOG2;
    localparam int FC_MAX   = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int FC_W     = (FC_MAX > 2) ? $clog2(FC_MAX) : 1;
    localparam logic [OFS_W-1:0] OFS_START  = OFS_W'(MSG_PIX);
    localparam logic [OFS_W-1:0] OFS_STEP   = OFS_W'(SCROLL_STEP);
    localparam logic [OFS_W-1:0] OFS_ZERO   = OFS_W'(0);
    localparam logic [FC_W-1:0]  HOLD_LAST  = FC_W'(HOLD_FRAMES - 1);
    localparam logic [FC_W-1:0]  BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0]  FC_ZERO    = FC_W'(0);
    localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);

    mode_e            mode_q, mode_d, mode_req_s;
    state_e           state_q, state_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic             anim_done_q;

    // Request priority: dead > win > init > play.
    always_comb begin
        mode_req_s = MODE_PLAY;
        if (dead_i) begin
            mode_req_s = MODE_DEAD;
        end else if (win_i) begin
            mode_req_s = MODE_WIN;
        end else if (init_i) begin
            mode_req_s = MODE_INIT;
        end else begin
            mode_req_s = MODE_PLAY;
        end
    end

    // Next-state logic; a mode change preempts the normal sequencing.
    always_comb begin
        mode_d      = mode_q;
        state_d     = state_q;
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_start_i) begin
            if (mode_req_s != mode_q) begin
                mode_d = mode_req_s;
                if (mode_req_s == MODE_PLAY) begin
                    state_d  = ST_PLAY;
                    offset_d = OFS_ZERO;
                end else begin
                    state_d     = ST_SCROLL;
                    offset_d    = OFS_START;
                    frame_cnt_d = FC_ZERO;
                    blink_on_d  = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_SCROLL: begin
                        if (offset_q > OFS_STEP) begin
                            offset_d = offset_q - OFS_STEP;
                        end else begin
                            offset_d    = OFS_ZERO;
                            state_d     = ST_HOLD;
                            frame_cnt_d = FC_ZERO;
                        end
                    end
                    ST_HOLD: begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_d     = ST_BLINK;
                            frame_cnt_d = FC_ZERO;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FC_ONE;
                        end
                    end
                    ST_BLINK: begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            blink_on_d  = ~blink_on_q;
                            frame_cnt_d = FC_ZERO;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FC_ONE;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers; anim_done is registered alongside the state it reflects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_PLAY;
            state_q     <= ST_PLAY;
            offset_q    <= OFS_ZERO;
            frame_cnt_q <= FC_ZERO;
            blink_on_q  <= 1'b1;
            anim_done_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            state_q     <= state_d;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            anim_done_q <= (state_d == ST_HOLD) || (state_d == ST_BLINK);
        end
    end

    assign mode_o      = mode_q;
    assign state_o     = state_q;
    assign offset_o    = offset_q;
    assign blink_on_o  = blink_on_q;
    assign anim_done_o = anim_done_q;

endmodule

// File: rtl/draw_back_anim.sv
// Animated background renderer: border plus a scrolling, blinking tiled
// message inside the playfield. Output is registered, one clock after the counters.
module draw_back_anim #(
    parameter int LEFT         = draw_back_anim_pkg::LEFT,
    parameter int TOP          = draw_back_anim_pkg::TOP,
    parameter int MAXX         = draw_back_anim_pkg::MAXX,
    parameter int MAXY         = draw_back_anim_pkg::MAXY,
    parameter int BORDER       = draw_back_anim_pkg::BORDER,
    parameter int TILE_LOG2    = draw_back_anim_pkg::TILE_LOG2,
    parameter int MSG_ROWS     = draw_back_anim_pkg::MSG_ROWS,
    parameter int BAND1_ROW    = draw_back_anim_pkg::BAND1_ROW,
    parameter int BAND2_ROW    = draw_back_anim_pkg::BAND2_ROW,
    parameter int SCROLL_STEP  = draw_back_anim_pkg::SCROLL_STEP,
    parameter int HOLD_FRAMES  = draw_back_anim_pkg::HOLD_FRAMES,
    parameter int BLINK_FRAMES = draw_back_anim_pkg::BLINK_FRAMES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcounter,
    input  logic [11:0] hcounter,
    input  logic        frame_start,
    input  logic        dead,
    input  logic        init,
    input  logic        win,
    output logic [3:0]  out,
    output logic        anim_done
);
    import draw_back_anim_pkg::*;

    localparam int MSG_PIX = MSG_ROWS << TILE_LOG2;
    localparam int OFS_W   = $clog2(MSG_PIX + 1);
    localparam int CW      = 14;

    localparam logic [CW-1:0] P_TOP      = CW'(TOP);
    localparam logic [CW-1:0] P_LEFT     = CW'(LEFT);
    localparam logic [CW-1:0] P_BORDER   = CW'(BORDER);
    localparam logic [CW-1:0] P_VEND     = CW'(TOP + MAXY);
    localparam logic [CW-1:0] P_HEND     = CW'(LEFT + MAXX);
    localparam logic [CW-1:0] P_MSG_END  = CW'(TOP + MSG_PIX);
    localparam logic [CW-1:0] P_VBRD_END = CW'(TOP + MAXY + BORDER);
    localparam logic [CW-1:0] P_HBRD_END = CW'(LEFT + MAXX + BORDER);
    localparam logic [4:0]    R_BAND1    = 5'(BAND1_ROW);
    localparam logic [4:0]    R_BAND2    = 5'(BAND2_ROW);
    localparam logic [4:0]    R_SUB_LO   = 5'(SUB_ROW_LO);
    localparam logic [4:0]    R_SUB_HI   = 5'(SUB_ROW_HI);
    localparam logic [4:0]    C_SUB_LO   = 5'(SUB_COL_LO);
    localparam logic [4:0]    C_SUB_HI   = 5'((MAXX >> TILE_LOG2) - 6);

    logic [1:0]       mode_s;
    logic [1:0]       state_s;
    logic [OFS_W-1:0] offset_s;
    logic             blink_on_s;
    logic             anim_done_s;

    logic [CW-1:0] v_s, h_s, ofs_s, sv_s, hx_s;
    logic          in_v_s, in_h_s, near_v_s, near_h_s, in_msg_s, sv_ok_s;
    logic [4:0]    tile_row_s, tile_col_s;
    logic [1:0]    sel_s;
    logic          glyph_s, lit_s;
    logic [3:0]    colour_s, pix_d;
    logic [3:0]    out_q;

    draw_back_anim_ctrl #(
        .MSG_ROWS     (MSG_ROWS),
        .TILE_LOG2    (TILE_LOG2),
        .SCROLL_STEP  (SCROLL_STEP),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .OFS_W        (OFS_W)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start),
        .dead_i        (dead),
        .init_i        (init),
        .win_i         (win),
        .mode_o        (mode_s),
        .state_o       (state_s),
        .offset_o      (offset_s),
        .blink_on_o    (blink_on_s),
        .anim_done_o   (anim_done_s)
    );

    // Region decode on widened counters so that +BORDER never wraps.
    always_comb begin
        v_s      = {3'b000, vcounter};
        h_s      = {2'b00, hcounter};
        ofs_s    = {{(CW - OFS_W){1'b0}}, offset_s};
        in_v_s   = (v_s >= P_TOP) && (v_s < P_VEND);
        in_h_s   = (h_s >= P_LEFT) && (h_s < P_HEND);
        near_v_s = ((v_s + P_BORDER) >= P_TOP) && (v_s < P_VBRD_END);
        near_h_s = ((h_s + P_BORDER) >= P_LEFT) && (h_s < P_HBRD_END);
        in_msg_s = (v_s >= P_TOP) && (v_s < P_MSG_END) && in_h_s;
        sv_ok_s  = v_s >= (P_TOP + ofs_s);
        sv_s     = v_s - P_TOP - ofs_s;
        hx_s     = h_s - P_LEFT;
        tile_row_s = 5'(sv_s >> TILE_LOG2);
        tile_col_s = 5'(hx_s >> TILE_LOG2);
    end

    // Glyph lookup and message colouring for the current mode.
    always_comb begin
        case (mode_s)
            MODE_DEAD: sel_s = SEL_DEAD;
            MODE_WIN:  sel_s = SEL_WIN;
            default:   sel_s = SEL_INIT;
        endcase
        glyph_s = glyph_bit(sel_s, tile_row_s, tile_col_s);
        lit_s   = glyph_s && (mode_s != MODE_PLAY) && in_msg_s && sv_ok_s &&
                  ((state_s != ST_BLINK) || blink_on_s);
        case (mode_s)
            MODE_DEAD: begin
                if (tile_row_s < R_BAND1) begin
                    colour_s = DEAD_A;
                end else if (tile_row_s < R_BAND2) begin
                    colour_s = DEAD_B;
                end else begin
                    colour_s = DEAD_C;
                end
            end
            MODE_INIT: begin
                if ((tile_row_s >= R_SUB_LO) && (tile_row_s <= R_SUB_HI) &&
                    (tile_col_s >= C_SUB_LO) && (tile_col_s <= C_SUB_HI)) begin
                    colour_s = INIT_B;
                end else if (tile_row_s < R_BAND2) begin
                    colour_s = INIT_A;
                end else begin
                    colour_s = INIT_B;
                end
            end
            MODE_WIN: colour_s = WIN_C;
            default:  colour_s = BLANK_C;
        endcase
    end

    // Final pixel select; border corners outside both spans stay blank.
    always_comb begin
        pix_d = BLANK_C;
        if (in_v_s && in_h_s) begin
            if (lit_s) begin
                pix_d = colour_s;
            end else begin
                pix_d = BLANK_C;
            end
        end else if ((in_v_s && near_h_s) || (in_h_s && near_v_s)) begin
            pix_d = BORDER_C;
        end else begin
            pix_d = BLANK_C;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= BLANK_C;
        end else begin
            out_q <= pix_d;
        end
    end

    assign out       = out_q;
    assign anim_done = anim_done_s;

endmodule

// File: tb/tb_draw_back_anim.sv
// Directed + randomized bench for draw_back_anim with a frame-count based reference model.
module tb_draw_back_anim;

    localparam int TOP = 16, LEFT = 16, MAXX = 512, MAXY = 448, BORDER = 72;
    localparam int MSGPIX = 288, SCROLL_FR = 36, HOLD_FR = 60, BLINK_FR = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] vcounter = 11'd0;
    logic [11:0] hcounter = 12'd0;
    logic        frame_start = 1'b0;
    logic        dead = 1'b0;
    logic        init = 1'b0;
    logic        win = 1'b0;
    logic [3:0]  out;
    logic        anim_done;

    int checks = 0;
    int errors = 0;
    int m_mode = 0;   // 0 play, 1 init, 2 dead, 3 win
    int m_n    = 0;   // frame_starts since the current message mode was latched

    draw_back_anim dut (
        .clk(clk), .rst_n(rst_n), .vcounter(vcounter), .hcounter(hcounter),
        .frame_start(frame_start), .dead(dead), .init(init), .win(win),
        .out(out), .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    function automatic int req_mode();
        if (dead) return 2;
        if (win)  return 3;
        if (init) return 1;
        return 0;
    endfunction

    function automatic int m_off();
        if (m_mode == 0 || m_n >= SCROLL_FR) return 0;
        return MSGPIX - 8 * m_n;
    endfunction

    function automatic bit m_done();
        return (m_mode != 0) && (m_n >= SCROLL_FR);
    endfunction

    function automatic bit m_hidden();
        if (m_n < SCROLL_FR + HOLD_FR) return 1'b0;
        return (((m_n - SCROLL_FR - HOLD_FR) / BLINK_FR) % 2) == 1;
    endfunction

    function automatic logic [3:0] exp_pix(input int v, input int h);
        bit vin, hin;
        int off, row, col;
        logic [4:0] r5, c5;
        logic [1:0] sel;
        vin = (v >= TOP) && (v < TOP + MAXY);
        hin = (h >= LEFT) && (h < LEFT + MAXX);
        if (vin && hin) begin
            off = m_off();
            if (m_mode != 0 && v < TOP + MSGPIX && v >= TOP + off && !m_hidden()) begin
                row = (v - TOP - off) / 16;
                col = (h - LEFT) / 16;
                r5  = row[4:0];
                c5  = col[4:0];
                sel = (m_mode == 1) ? 2'b00 : (m_mode == 2) ? 2'b01 : 2'b11;
                if (draw_back_anim_pkg::glyph_bit(sel, r5, c5)) begin
                    if (m_mode == 3) return 4'b1101;
                    if (m_mode == 2) return (row < 6) ? 4'b1011 : (row < 12) ? 4'b1100 : 4'b1010;
                    if (row >= 6 && row <= 8 && col >= 5 && col <= MAXX / 16 - 6) return 4'b1100;
                    return (row < 12) ? 4'b1110 : 4'b1100;
                end
            end
            return 4'b0000;
        end
        if (vin && ((h < LEFT) ? (LEFT - h <= BORDER) : (h - (LEFT + MAXX) < BORDER))) return 4'b1111;
        if (hin && ((v < TOP) ? (TOP - v <= BORDER) : (v - (TOP + MAXY) < BORDER))) return 4'b1111;
        return 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (req_mode() != m_mode) begin
            m_mode = req_mode();
            m_n    = 0;
        end else if (m_mode != 0) begin
            m_n++;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pix(input string tag, input int v, input int h);
        @(negedge clk);
        vcounter = v[10:0];
        hcounter = h[11:0];
        @(negedge clk);
        chk(tag, out, exp_pix(v, h));
        chk("anim_done", {3'b000, anim_done}, {3'b000, m_done()});
    endtask

    task automatic rand_pix(input string tag, input int n);
        int v, h;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                v = $urandom_range(TOP, TOP + MSGPIX - 1);
                h = $urandom_range(LEFT, LEFT + MAXX - 1);
            end else begin
                v = $urandom_range(0, 620);
                h = $urandom_range(0, 700);
            end
            pix(tag, v, h);
        end
    endtask

    initial begin
        #1;
        chk("reset_out", out, 4'b0000);
        chk("reset_done", {3'b000, anim_done}, 4'b0000);
        frame_start = 1'b1;
        #22;
        frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        pix("border_left", TOP, LEFT - 1);
        pix("corner_blank", 0, 0);
        pix("border_right", TOP + 5, LEFT + MAXX + BORDER - 1);
        pix("beyond_border", TOP + 5, LEFT + MAXX + BORDER);
        pix("border_bottom", TOP + MAXY, LEFT + 3);
        rand_pix("play_rand", 10);

        dead = 1'b1;
        frame();
        pix("scroll_start", TOP + 2, LEFT);
        rand_pix("dead_scroll288", 10);
        frames(18);
        pix("above_offset", TOP + 100, LEFT);
        pix("row0_at_144", TOP + 144, LEFT);
        rand_pix("dead_scroll144", 15);
        frames(18);
        pix("dead_row2", TOP + 32, LEFT);
        rand_pix("dead_hold", 20);

        frames(59);
        pix("hold_end", TOP, LEFT);
        frame();
        pix("blink_entry", TOP, LEFT);
        frames(30);
        pix("blink_off", TOP, LEFT);
        rand_pix("blink_off_rand", 10);
        frames(30);
        pix("blink_on_again", TOP, LEFT);
        rand_pix("blink_on_rand", 10);

        win = 1'b1;
        frame();
        pix("dead_over_win", TOP + 32, LEFT);

        dead = 1'b0;
        win  = 1'b0;
        frame();
        pix("play_field", TOP + 32, LEFT);
        pix("play_border", TOP, LEFT - 1);
        rand_pix("play_again", 10);

        dead = 1'b1;
        win  = 1'b1;
        frame();
        frames(5);
        rand_pix("dead_win_scroll", 10);
        dead = 1'b0;
        frame();
        pix("win_restart", TOP + 2, LEFT);
        frames(SCROLL_FR);
        pix("win_lit", TOP, LEFT);
        rand_pix("win_hold", 15);

        win  = 1'b0;
        init = 1'b1;
        frame();
        frames(SCROLL_FR + 10);
        for (int c = 0; c < 32; c++) pix("init_row7", TOP + 7 * 16 + 3, LEFT + c * 16);
        rand_pix("init_hold", 15);
        frames(HOLD_FR + 5);
        pix("init_blink", TOP + 40, LEFT + 40);

        @(negedge clk);
        vcounter = TOP[10:0];
        hcounter = 12'(LEFT - 1);
        @(negedge clk);
        chk("pre_reset_border", out, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", out, 4'b0000);
        chk("async_reset_done", {3'b000, anim_done}, 4'b0000);
        m_mode = 0;
        m_n    = 0;
        init   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pix("after_reset_field", TOP + 40, LEFT + 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
